// File: rtl/pe_generic.sv
// Echo-state-network readout PE: signed fixed-point products of D against nout weight rows,
// reduced pairwise with round-half-up and saturation into registered partial sums.
module pe_generic #(
    parameter int unsigned width = 16,
    parameter int unsigned ndata = 16,
    parameter int unsigned nout  = 4,
    localparam int unsigned nweight = ndata * nout,
    localparam int unsigned nq      = nweight / 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ce,
    input  logic [1:0]               mode,
    input  logic [width*ndata-1:0]   D,
    input  logic [width*nweight-1:0] W,
    output logic [width*nq-1:0]      Q
);

    localparam int unsigned half = width / 2;

    localparam logic signed [2*width:0] rnd     = {{(2*width){1'b0}}, 1'b1} << (half - 1);
    localparam logic signed [2*width:0] sat_max = {{(width+2){1'b0}}, {(width-1){1'b1}}};
    localparam logic signed [2*width:0] sat_min = {{(width+2){1'b1}}, {(width-1){1'b0}}};

    logic signed [2*width-1:0] prod_d [nweight];
    logic signed [2*width-1:0] prod_q [nweight];
    logic                      v1_q;
    logic [width*nq-1:0]       q_d;
    logic [width*nq-1:0]       q_q;

    // Product j pairs weight word j with state word j mod ndata.
    for (genvar j = 0; j < nweight; j++) begin : g_prod
        logic signed [2*width-1:0] dx;
        logic signed [2*width-1:0] wx;
        assign dx = {{width{D[(j%ndata+1)*width-1]}}, D[(j%ndata)*width +: width]};
        assign wx = {{width{W[(j+1)*width-1]}}, W[j*width +: width]};
        assign prod_d[j] = dx * wx;
    end

    for (genvar l = 0; l < nq; l++) begin : g_lane
        logic signed [2*width:0] s;
        logic signed [2*width:0] r;
        assign s = {prod_q[2*l][2*width-1], prod_q[2*l]}
                 + {prod_q[2*l+1][2*width-1], prod_q[2*l+1]};
        assign r = (s + rnd) >>> half;
        assign q_d[l*width +: width] = (r > sat_max) ? {1'b0, {(width-1){1'b1}}} :
                                       (r < sat_min) ? {1'b1, {(width-1){1'b0}}} :
                                       r[width-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < nweight; j++) begin
                prod_q[j] <= '0;
            end
            v1_q <= 1'b0;
            q_q  <= '0;
        end else if (ce) begin
            prod_q <= prod_d;
            v1_q   <= (mode == 2'b01);
            if (v1_q) begin
                q_q <= q_d;
            end
        end
    end

    assign Q = q_q;

endmodule

// File: tb/tb_pe_generic.sv
// Scoreboard bench for pe_generic: the driver queues expected Q words per cycle,
// a negedge monitor pops and compares them.
module tb_pe_generic;

    localparam int NDATA = 16;
    localparam int NOUT  = 4;
    localparam int NW    = NDATA * NOUT;
    localparam int NQ    = NW / 2;
    localparam int QW    = 16 * NQ;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ce;
    logic [1:0]        mode;
    logic [16*NDATA-1:0] D;
    logic [16*NW-1:0]    W;
    logic [QW-1:0]       Q;

    pe_generic #(.width(16), .ndata(NDATA), .nout(NOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ce    (ce),
        .mode  (mode),
        .D     (D),
        .W     (W),
        .Q     (Q)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            at;
        logic [QW-1:0] q;
        string         name;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   compared   = 0;
    int   mismatched = 0;

    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].at <= cyc) begin
            mon_e = sbq.pop_front();
            compared++;
            if (mon_e.at < cyc || Q !== mon_e.q) begin
                mismatched++;
                $display("FAIL %s (cycle %0d): got %h expected %h", mon_e.name, cyc, Q, mon_e.q);
            end
        end
    end

    function automatic logic [QW-1:0] rep(input logic [15:0] w);
        return {NQ{w}};
    endfunction

    // Independent integer reference for one lane.
    function automatic logic [15:0] ref_lane(input logic [15:0] d0, input logic [15:0] d1,
                                             input logic [15:0] w0, input logic [15:0] w1);
        longint p0, p1, r;
        p0 = longint'($signed(d0)) * longint'($signed(w0));
        p1 = longint'($signed(d1)) * longint'($signed(w1));
        r  = (p0 + p1 + 128) >>> 8;
        if (r > 32767)  return 16'h7fff;
        if (r < -32768) return 16'h8000;
        return r[15:0];
    endfunction

    task automatic push(input int off, input logic [QW-1:0] v, input string nm);
        exp_t e;
        e.at   = cyc + off;
        e.q    = v;
        e.name = nm;
        sbq.push_back(e);
    endtask

    task automatic step_vec(input logic c, input logic [1:0] m,
                            input logic [16*NDATA-1:0] dv, input logic [16*NW-1:0] wv);
        @(posedge clk);
        #1;
        ce   = c;
        mode = m;
        D    = dv;
        W    = wv;
    endtask

    task automatic step(input logic c, input logic [1:0] m,
                        input logic [15:0] dw, input logic [15:0] ww);
        step_vec(c, m, {NDATA{dw}}, {NW{ww}});
    endtask

    logic [16*NDATA-1:0] ramp_d;
    logic [16*NW-1:0]    ramp_w;
    logic [QW-1:0]       ramp_q;

    initial begin
        rst_n = 1'b0;
        ce    = 1'b0;
        mode  = 2'b00;
        D     = '0;
        W     = '0;

        for (int i = 0; i < NDATA; i++) ramp_d[16*i +: 16] = 16'(16'h0100 * (i + 1));
        for (int r = 0; r < NOUT; r++) begin
            for (int j = 0; j < NDATA; j++) begin
                case (r)
                    0:       ramp_w[16*(r*NDATA+j) +: 16] = 16'h0100;
                    1:       ramp_w[16*(r*NDATA+j) +: 16] = 16'h0180;
                    2:       ramp_w[16*(r*NDATA+j) +: 16] = 16'hff40;
                    default: ramp_w[16*(r*NDATA+j) +: 16] = 16'(16'h0081 + j);
                endcase
            end
        end
        for (int r = 0; r < NOUT; r++) begin
            for (int k = 0; k < NDATA / 2; k++) begin
                ramp_q[16*(r*NDATA/2+k) +: 16] = ref_lane(ramp_d[16*(2*k) +: 16],
                                                          ramp_d[16*(2*k+1) +: 16],
                                                          ramp_w[16*(r*NDATA+2*k) +: 16],
                                                          ramp_w[16*(r*NDATA+2*k+1) +: 16]);
            end
        end

        repeat (2) @(posedge clk);
        step(1'b0, 2'b00, 16'h0000, 16'h0000);
        push(0, '0, "reset_state");
        rst_n = 1'b1;

        step(1'b1, 2'b01, 16'h0100, 16'h0200);
        push(1, '0, "first_edge_empty");
        push(2, rep(16'h0400), "one_times_two");
        step(1'b1, 2'b01, 16'hff00, 16'h0100); push(2, rep(16'hfe00), "neg_one");
        step(1'b1, 2'b01, 16'hff00, 16'h8000); push(2, rep(16'h7fff), "pos_sat");
        step(1'b1, 2'b01, 16'h8000, 16'h7fff); push(2, rep(16'h8000), "neg_sat");
        step(1'b1, 2'b01, 16'h0001, 16'h0080); push(2, rep(16'h0001), "round_half_up");
        step(1'b1, 2'b01, 16'h0001, 16'hffc0); push(2, rep(16'h0000), "round_neg_half");
        step(1'b1, 2'b01, 16'h0001, 16'hffbf); push(2, rep(16'hffff), "round_neg");

        // Mode switch: the last MVM sample still lands, then Q freezes.
        step(1'b1, 2'b01, 16'h0100, 16'h0200); push(2, rep(16'h0400), "pre_switch");
        step(1'b1, 2'b00, 16'h0200, 16'h0200); push(2, rep(16'h0400), "update_hold");
        step(1'b1, 2'b10, 16'h0200, 16'h0200); push(2, rep(16'h0400), "reserved10_hold");
        step(1'b1, 2'b11, 16'h0200, 16'h0200); push(2, rep(16'h0400), "reserved11_hold");
        step(1'b1, 2'b00, 16'h0200, 16'h0200); push(2, rep(16'h0400), "update_hold2");
        step(1'b1, 2'b01, 16'h0200, 16'h0200); push(2, rep(16'h0800), "resume_mvm");

        step_vec(1'b1, 2'b01, ramp_d, ramp_w); push(2, ramp_q, "ramp_lanes");
        step(1'b1, 2'b01, 16'h0100, 16'h0200);
        step(1'b1, 2'b01, 16'h0100, 16'h0200);

        // Async reset mid-stream with data in flight.
        step(1'b0, 2'b01, 16'h0b2a, 16'h2f04);
        rst_n = 1'b0;
        push(0, '0, "async_reset");
        step(1'b0, 2'b01, 16'h0b2a, 16'h2f04);
        rst_n = 1'b1;
        push(1, '0, "stall_zero");
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 2'b01, 16'h0b2a, 16'h2f04);
            push(1, '0, "stall_zero");
        end
        step(1'b1, 2'b01, 16'h0b2a, 16'h2f04);
        push(1, '0, "post_reset_first_edge");
        push(2, rep(16'h7fff), "stall_release_sat");

        // Stall with a sample in stage 1; it must survive and emerge on resume.
        step(1'b1, 2'b01, 16'h0100, 16'h0200);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 2'b01, 16'h0200, 16'h0200);
            push(1, rep(16'h7fff), "stall_hold");
        end
        step(1'b1, 2'b01, 16'h0200, 16'h0200);
        push(1, rep(16'h0400), "inflight_resume");
        push(2, rep(16'h0800), "after_stall");
        step(1'b1, 2'b00, 16'h0000, 16'h0000);
        step(1'b1, 2'b00, 16'h0000, 16'h0000);

        repeat (3) @(negedge clk);
        #1;
        compared++;
        if (sbq.size() != 0) begin
            mismatched++;
            $display("FAIL drain: got %0d pending expected 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
